// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers, bursts of up to MAX_BURST.
// Optional write/stall statistics counters are built when FIFO_WR_ARBITER_STATS_EN is defined.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_full,
    input  logic                          fifo_wr_ack,
    input  logic                          fifo_overflow,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    owner_id,
    output logic                          err_overflow,
    output logic [15:0]                   stat_wr_cnt,
    output logic [15:0]                   stat_stall_cnt
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_owner_id;
    logic [CNT_W-1:0]   r_burst_cnt;
    logic               r_err_overflow;

    logic [FIFO_WIDTH-1:0] w_slice [NUM_REQ];
    logic [IDX_W-1:0]      w_next_owner;
    logic                  w_found;
    logic                  w_in_burst;
    logic                  w_owner_req;
    logic                  w_grant;
    logic                  w_last;
    logic                  w_exit;

    // Index arithmetic modulo NUM_REQ, valid for non-power-of-two requester counts.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return IDX_W'(sum);
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign w_slice[g] = req_data[g*FIFO_WIDTH +: FIFO_WIDTH];
    end

    assign w_in_burst  = (r_state == ST_BURST);
    assign w_owner_req = req[r_owner_id];
    assign w_grant     = w_in_burst & w_owner_req & ~fifo_full;
    assign w_last      = (r_burst_cnt == CNT_W'(MAX_BURST - 1));
    assign w_exit      = w_in_burst & (~w_owner_req | (w_grant & w_last));

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        w_next_owner = r_rr_ptr;
        w_found      = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req[wrap_add(r_rr_ptr, k)]) begin
                w_found      = 1'b1;
                w_next_owner = wrap_add(r_rr_ptr, k);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_rr_ptr       <= '0;
            r_owner_id     <= '0;
            r_burst_cnt    <= '0;
            r_err_overflow <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_owner_id  <= w_next_owner;
                        r_burst_cnt <= '0;
                        r_state     <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (w_grant) r_burst_cnt <= r_burst_cnt + 1'b1;
                    if (w_exit) begin
                        r_state  <= ST_IDLE;
                        r_rr_ptr <= wrap_add(r_owner_id, 1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (fifo_overflow) r_err_overflow <= 1'b1;
        end
    end

    // Grant is combinational so a full FIFO or reset removes it within the same cycle.
    always_comb begin
        gnt = '0;
        if (w_grant) gnt[r_owner_id] = 1'b1;
    end

    assign fifo_wr_en   = w_grant;
    assign fifo_data_in = w_slice[r_owner_id];
    assign busy         = w_in_burst;
    assign owner_id     = r_owner_id;
    assign err_overflow = r_err_overflow;

`ifdef FIFO_WR_ARBITER_STATS_EN
    logic [15:0] r_stat_wr_cnt;
    logic [15:0] r_stat_stall_cnt;
    logic        w_stall;

    assign w_stall = w_in_burst & w_owner_req & fifo_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_wr_cnt    <= '0;
            r_stat_stall_cnt <= '0;
        end else begin
            if (fifo_wr_ack && (r_stat_wr_cnt != 16'hFFFF)) r_stat_wr_cnt <= r_stat_wr_cnt + 16'd1;
            if (w_stall && (r_stat_stall_cnt != 16'hFFFF)) r_stat_stall_cnt <= r_stat_stall_cnt + 16'd1;
        end
    end

    assign stat_wr_cnt    = r_stat_wr_cnt;
    assign stat_stall_cnt = r_stat_stall_cnt;
`else
    logic w_unused_ack;

    assign w_unused_ack   = fifo_wr_ack;
    assign stat_wr_cnt    = '0;
    assign stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random traffic against a behavioural model.
// Honours FIFO_WR_ARBITER_STATS_EN to choose expected statistics values.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int MB = 4;
`ifdef FIFO_WR_ARBITER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic [N-1:0]     req;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     gnt;
    logic             fifo_wr_en;
    logic [W-1:0]     fifo_data_in;
    logic             fifo_full;
    logic             fifo_wr_ack;
    logic             fifo_overflow;
    logic             busy;
    logic [1:0]       owner_id;
    logic             err_overflow;
    logic [15:0]      stat_wr_cnt;
    logic [15:0]      stat_stall_cnt;

    fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .MAX_BURST(MB)) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .req_data       (req_data),
        .gnt            (gnt),
        .fifo_wr_en     (fifo_wr_en),
        .fifo_data_in   (fifo_data_in),
        .fifo_full      (fifo_full),
        .fifo_wr_ack    (fifo_wr_ack),
        .fifo_overflow  (fifo_overflow),
        .busy           (busy),
        .owner_id       (owner_id),
        .err_overflow   (err_overflow),
        .stat_wr_cnt    (stat_wr_cnt),
        .stat_stall_cnt (stat_stall_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who owns the port, how many grants so far, where the next search starts.
    bit m_busy;
    int m_owner, m_cnt, m_ptr;
    bit m_err;
    int m_wr, m_stall;

    // Observations taken from the DUT, compared later to scenario constants.
    int obs_cnt [N];
    int obs_total;
    int owner_seq [$];
    bit prev_gnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
        m_err = 0; m_wr = 0; m_stall = 0;
    endtask

    task automatic obs_clear();
        for (int i = 0; i < N; i++) obs_cnt[i] = 0;
        obs_total = 0;
        owner_seq.delete();
        prev_gnt = 0;
    endtask

    task automatic check_outputs();
        bit           exp_grant;
        logic [N-1:0] exp_gnt;
        exp_grant = m_busy && req[m_owner] && !fifo_full;
        exp_gnt = '0;
        if (exp_grant) exp_gnt[m_owner] = 1'b1;
        check("gnt", 32'(gnt), 32'(exp_gnt));
        check("wr_en", 32'(fifo_wr_en), 32'(exp_grant));
        check("busy", 32'(busy), 32'(m_busy));
        check("owner_id", 32'(owner_id), 32'(m_owner));
        check("err_overflow", 32'(err_overflow), 32'(m_err));
        check("stat_wr", 32'(stat_wr_cnt), STATS ? 32'(m_wr) : 32'd0);
        check("stat_stall", 32'(stat_stall_cnt), STATS ? 32'(m_stall) : 32'd0);
        if (m_busy) check("data_in", 32'(fifo_data_in), 32'(req_data[m_owner*W +: W]));
        if (gnt != '0) begin
            for (int i = 0; i < N; i++) begin
                if (gnt[i]) begin
                    obs_cnt[i]++;
                    if (!prev_gnt) owner_seq.push_back(i);
                end
            end
            obs_total++;
        end
        prev_gnt = (gnt != '0);
    endtask

    task automatic model_update();
        bit picked;
        if (fifo_overflow) m_err = 1;
        if (fifo_wr_ack && m_wr < 65535) m_wr++;
        if (m_busy && req[m_owner] && fifo_full && m_stall < 65535) m_stall++;
        if (!m_busy) begin
            if (req != '0) begin
                picked = 0;
                for (int k = 0; k < N; k++) begin
                    if (!picked && req[(m_ptr + k) % N]) begin
                        picked  = 1;
                        m_owner = (m_ptr + k) % N;
                    end
                end
                m_cnt  = 0;
                m_busy = 1;
            end
        end else if (!req[m_owner]) begin
            m_busy = 0;
            m_ptr  = (m_owner + 1) % N;
        end else if (!fifo_full) begin
            m_cnt++;
            if (m_cnt == MB) begin
                m_busy = 0;
                m_ptr  = (m_owner + 1) % N;
            end
        end
    endtask

    // Called at posedge+1; leaves at the following posedge+1.
    task automatic step(input logic [N-1:0] r, input logic full, input logic ack, input logic ovf);
        req = r;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
        fifo_full     = full;
        fifo_wr_ack   = ack;
        fifo_overflow = ovf;
        #3;
        check_outputs();
        model_update();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset: outputs must drop before any clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_owner", 32'(owner_id), 32'd0);
        check("rst_err", 32'(err_overflow), 32'd0);
        check("rst_stat_wr", 32'(stat_wr_cnt), 32'd0);
        check("rst_stat_stall", 32'(stat_stall_cnt), 32'd0);
        model_reset();
        obs_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] rq;
        clk = 0; rst = 1; req = '0; req_data = '0;
        fifo_full = 0; fifo_wr_ack = 0; fifo_overflow = 0;
        model_reset();
        obs_clear();
        @(posedge clk);
        #1;

        // Reset with every requester asking.
        req = '1;
        do_reset();

        // Single requester: bubble, 4 grants, bubble, regrant; then reset mid-burst.
        repeat (7) step(4'b0100, 0, 0, 0);
        check("t2_cnt2", 32'(obs_cnt[2]), 32'd5);
        check("t2_total", 32'(obs_total), 32'd5);
        step(4'b0100, 0, 0, 0);
        do_reset();

        // All requesters: 16 grants in 20 cycles, owner order 0,1,2,3,0.
        repeat (21) step(4'b1111, 0, 0, 0);
        check("t3_total", 32'(obs_total), 32'd16);
        repeat (4) step(4'b1111, 0, 0, 0);
        check("t3_bursts", 32'(owner_seq.size()), 32'd5);
        if (owner_seq.size() == 5) begin
            check("t3_own0", 32'(owner_seq[0]), 32'd0);
            check("t3_own1", 32'(owner_seq[1]), 32'd1);
            check("t3_own2", 32'(owner_seq[2]), 32'd2);
            check("t3_own3", 32'(owner_seq[3]), 32'd3);
            check("t3_own4", 32'(owner_seq[4]), 32'd0);
        end
        do_reset();

        // Full stall after the 2nd grant: burst still totals 4 grants.
        step(4'b0001, 0, 0, 0);
        repeat (2) step(4'b0001, 0, 0, 0);
        repeat (3) step(4'b0001, 1, 0, 0);
        check("t4_stalled_cnt", 32'(obs_cnt[0]), 32'd2);
        repeat (2) step(4'b0001, 0, 0, 0);
        step(4'b0001, 0, 0, 0);
        check("t4_cnt0", 32'(obs_cnt[0]), 32'd4);
        check("t4_stall_stat", 32'(stat_stall_cnt), STATS ? 32'd3 : 32'd0);
        do_reset();

        // Early release by owner 1; pointer moves to 2 so requester 3 wins over 0.
        repeat (3) step(4'b1010, 0, 0, 0);
        step(4'b1001, 0, 0, 0);
        check("t5_idle", 32'(busy), 32'd0);
        repeat (3) step(4'b1001, 0, 0, 0);
        check("t5_owner", 32'(owner_id), 32'd3);
        step(4'b0001, 0, 0, 0);
        check("t5_cnt1", 32'(obs_cnt[1]), 32'd2);
        check("t5_cnt3", 32'(obs_cnt[3]), 32'd2);
        check("t5_cnt0", 32'(obs_cnt[0]), 32'd0);
        do_reset();

        // Overflow is sticky; write acks feed the statistics.
        step(4'b0000, 0, 0, 1);
        repeat (3) step(4'b0000, 0, 0, 0);
        check("t6_err", 32'(err_overflow), 32'd1);
        repeat (5) step(4'b0000, 0, 1, 0);
        step(4'b0000, 0, 0, 0);
        check("t6_wr_stat", 32'(stat_wr_cnt), STATS ? 32'd5 : 32'd0);
        check("t6_err_hold", 32'(err_overflow), 32'd1);
        do_reset();

        // Random traffic against the model.
        rq = '0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) rq = N'($urandom);
            step(rq, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 299) == 0);
            if (c % 1000 == 999) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter that shares the single write port of the synchronous FIFO between NUM_REQ producers. Each producer is granted a burst of up to MAX_BURST writes. Writes are gated on the FIFO full flag, so the FIFO's write port is never driven while it is full. The block sits directly in front of the FIFO: its fifo_* outputs drive the FIFO's data_in and wr_en, and its fifo_* inputs take the FIFO's full, wr_ack and overflow flags.

Parameters:
NUM_REQ, 4, number of requesters; must be >= 2, any integer.
FIFO_WIDTH, 16, data width; matches the FIFO.
MAX_BURST, 4, maximum consecutive grants per ownership; must be >= 1.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
req  in  NUM_REQ  per-requester write request; level signal.
req_data  in  NUM_REQ*FIFO_WIDTH  packed data; requester i occupies bits [i*FIFO_WIDTH +: FIFO_WIDTH].
gnt  out  NUM_REQ  one-hot; gnt[i]=1 means requester i's data is written this cycle.
fifo_wr_en  out  1  to FIFO wr_en.
fifo_data_in  out  FIFO_WIDTH  to FIFO data_in.
fifo_full  in  1  from FIFO full.
fifo_wr_ack  in  1  from FIFO wr_ack.
fifo_overflow  in  1  from FIFO overflow.
busy  out  1  1 while in BURST.
owner_id  out  $clog2(NUM_REQ)  current or last owner.
err_overflow  out  1  sticky: FIFO overflow was seen.
stat_wr_cnt  out  16  write-ack count (optional feature).
stat_stall_cnt  out  16  full-stall count (optional feature).

Behaviour:
- Reset (rst=1, asynchronous):
  - Registers: state=IDLE, rr_ptr=0, owner_id=0, burst_cnt=0, err_overflow=0, both stat counters=0.
  - Outputs: gnt=0, fifo_wr_en=0, busy=0.
  - Reset asserted mid-burst drops gnt and fifo_wr_en immediately; the partial burst is abandoned and nothing is replayed.
- Registered state: state {IDLE, BURST}, rr_ptr, owner_id, burst_cnt (width $clog2(MAX_BURST+1)).
- IDLE:
  - gnt=0, fifo_wr_en=0.
  - If |req: owner_id <= lowest index i found by searching from rr_ptr upward, wrapping NUM_REQ-1 -> 0, with req[i]=1. Then burst_cnt <= 0 and state <= BURST.
  - Arbitration latency is 1 cycle from req to the first possible gnt.
- BURST, combinational outputs:
  - gnt[owner_id] = req[owner_id] & ~fifo_full; all other gnt bits are 0.
  - fifo_wr_en = |gnt.
  - fifo_data_in = req_data slice of owner_id in every cycle, granted or not.
- BURST, on each grant: burst_cnt <= burst_cnt+1.
- BURST exit to IDLE at the next edge, either case:
  - (a) req[owner_id]=0.
  - (b) a grant occurs with burst_cnt == MAX_BURST-1.
  - On exit: rr_ptr <= owner_id+1, wrapping NUM_REQ-1 -> 0.
- fifo_full=1 in BURST: stall. No grant, burst_cnt holds, ownership retained. A stall never ends the burst; only req drop or burst completion does.
- After every burst there is exactly one IDLE bubble cycle before the next grant.
- A requester seeing gnt[i]=1 at an edge presents its next word, or drops req, in the following cycle.
- err_overflow <= 1 on any cycle with fifo_overflow=1; cleared only by rst.
- fifo_wr_ack is used only by the statistics feature.

Optional Feature:
Macro FIFO_WR_ARBITER_STATS_EN.
- Defined:
  - stat_wr_cnt increments on each cycle with fifo_wr_ack=1.
  - stat_stall_cnt increments on each cycle with state=BURST & req[owner_id] & fifo_full.
  - Both counters saturate at 16'hFFFF and are cleared by rst.
- Undefined: both stat ports remain in the interface, are tied to 0, and no counter logic is built.

Test Plan:
1. Reset: hold rst=1 with req=4'b1111 -> gnt=0, fifo_wr_en=0, busy=0, err_overflow=0, owner_id=0, stat counters=0.
2. Single requester: req=4'b0100 held, fifo_full=0, MAX_BURST=4 -> one IDLE cycle, then gnt=4'b0100 for 4 consecutive cycles with fifo_data_in equal to req_data[47:32]. Then one bubble, then requester 2 is granted again.
3. All requesters: req=4'b1111 held -> owner order 0,1,2,3,0, each with 4 grants, separated by 1-cycle bubbles. Total 16 grants in 20 cycles after the first IDLE.
4. Full stall: fifo_full=1 for 3 cycles after the 2nd grant -> gnt=0 and fifo_wr_en=0 during the stall, burst_cnt holds at 2. After full clears, exactly 2 more grants, then exit. With the macro, stat_stall_cnt=3.
5. Early release: owner 1 drops req after 2 grants while req[3]=1 -> IDLE next cycle with rr_ptr=2. Requester 3 is then owner, and the burst ends after 2 grants.
6. Overflow and statistics: pulse fifo_overflow=1 for one cycle -> err_overflow=1 and stays 1 until rst. With the macro, 5 fifo_wr_ack pulses give stat_wr_cnt=5.
